// File: rtl/sram25_fifo_ctrl.sv
// Ready/valid FIFO built on a 25x64 two-port SRAM macro plus a 2-entry output buffer.
// Define FIFO_BYPASS_EN to let words skip the SRAM when the queue is otherwise idle.
module sram25_fifo_ctrl #(
   parameter int unsigned DEPTH = 25,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned AW    = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             enq_valid_i,
   output logic             enq_ready_o,
   input  logic [WIDTH-1:0] enq_bits_i,
   output logic             deq_valid_o,
   input  logic             deq_ready_i,
   output logic [WIDTH-1:0] deq_bits_o,
   output logic [4:0]       count_o,
   output logic [AW-1:0]    ram_wr_addr_o,
   output logic [WIDTH-1:0] ram_wr_data_o,
   output logic             ram_wr_csb_o,
   output logic             ram_wr_web_o,
   output logic [AW-1:0]    ram_rd_addr_o,
   output logic             ram_rd_csb_o,
   output logic             ram_rd_oeb_o,
   input  logic [WIDTH-1:0] ram_rd_data_i
);

   localparam int unsigned CW = 5;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
   logic             rd_inflight_q, rd_inflight_d;
   logic [WIDTH-1:0] out_buf_q [2];
   logic [WIDTH-1:0] out_buf_d [2];
   logic             head_q, head_d;
   logic [1:0]       out_cnt_q, out_cnt_d;
   logic [4:0]       count_q, count_d;
   logic             enq_ready_q, enq_ready_d;

   logic             enq_fire_c;
   logic             deq_fire_c;
   logic             bypass_c;
   logic             wr_en_c;
   logic             rd_issue_c;
   logic [2:0]       occ_c;
   logic             tail_c;

   // Fire decode, read-issue throttling and optional bypass
   always_comb begin
      enq_fire_c = enq_valid_i & enq_ready_q;
      deq_fire_c = deq_ready_i & (out_cnt_q != 2'd0);
      occ_c      = 3'(out_cnt_q) + 3'(rd_inflight_q) - 3'(deq_fire_c);
`ifdef FIFO_BYPASS_EN
      bypass_c   = enq_fire_c & (ram_cnt_q == '0) & ~rd_inflight_q
                   & ((3'(out_cnt_q) - 3'(deq_fire_c)) < 3'd2);
`else
      bypass_c   = 1'b0;
`endif
      wr_en_c    = enq_fire_c & ~bypass_c;
      rd_issue_c = (ram_cnt_q != '0) & (occ_c < 3'd2);
      // Tail slot; with a full buffer only a same-cycle dequeue frees the head slot
      tail_c     = head_q ^ out_cnt_q[0];
   end

   // Next-state for pointers, counters and output buffer
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      ram_cnt_d     = ram_cnt_q;
      rd_inflight_d = rd_issue_c;
      out_buf_d     = out_buf_q;
      head_d        = head_q ^ deq_fire_c;
      out_cnt_d     = out_cnt_q;
      count_d       = count_q + 5'(enq_fire_c) - 5'(deq_fire_c);

      if (wr_en_c) begin
         wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
      end
      if (rd_issue_c) begin
         rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
      end
      ram_cnt_d = ram_cnt_q + CW'(wr_en_c) - CW'(rd_issue_c);

      if (rd_inflight_q) begin
         out_buf_d[tail_c] = ram_rd_data_i;
      end else if (bypass_c) begin
         out_buf_d[tail_c] = enq_bits_i;
      end
      out_cnt_d   = out_cnt_q + 2'(rd_inflight_q | bypass_c) - 2'(deq_fire_c);
      enq_ready_d = (ram_cnt_d < CW'(DEPTH));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         ram_cnt_q     <= '0;
         rd_inflight_q <= 1'b0;
         out_buf_q[0]  <= '0;
         out_buf_q[1]  <= '0;
         head_q        <= 1'b0;
         out_cnt_q     <= '0;
         count_q       <= '0;
         enq_ready_q   <= 1'b1;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         ram_cnt_q     <= ram_cnt_d;
         rd_inflight_q <= rd_inflight_d;
         out_buf_q[0]  <= out_buf_d[0];
         out_buf_q[1]  <= out_buf_d[1];
         head_q        <= head_d;
         out_cnt_q     <= out_cnt_d;
         count_q       <= count_d;
         enq_ready_q   <= enq_ready_d;
      end
   end

   // Macro strobes follow the same-cycle fire/issue decisions
   always_comb begin
      enq_ready_o   = enq_ready_q;
      deq_valid_o   = (out_cnt_q != 2'd0);
      deq_bits_o    = out_buf_q[head_q];
      count_o       = count_q;
      ram_wr_addr_o = wr_ptr_q;
      ram_wr_data_o = wr_en_c ? enq_bits_i : '0;
      ram_wr_csb_o  = ~wr_en_c;
      ram_wr_web_o  = ~wr_en_c;
      ram_rd_addr_o = rd_ptr_q;
      ram_rd_csb_o  = ~rd_issue_c;
      ram_rd_oeb_o  = 1'b0;
   end

endmodule

// File: tb/tb_sram25_fifo_ctrl.sv
// Directed + random bench for sram25_fifo_ctrl with a behavioural SRAM and scoreboard.
module tb_sram25_fifo_ctrl;

`ifdef FIFO_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 3;
`endif

   logic        clk;
   logic        rst;
   logic        enq_valid;
   logic        enq_ready;
   logic [63:0] enq_bits;
   logic        deq_valid;
   logic        deq_ready;
   logic [63:0] deq_bits;
   logic [4:0]  count;
   logic [4:0]  wr_addr;
   logic [63:0] wr_data;
   logic        wr_csb;
   logic        wr_web;
   logic [4:0]  rd_addr;
   logic        rd_csb;
   logic        rd_oeb;
   logic [63:0] rd_data;

   sram25_fifo_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .enq_valid_i   (enq_valid),
      .enq_ready_o   (enq_ready),
      .enq_bits_i    (enq_bits),
      .deq_valid_o   (deq_valid),
      .deq_ready_i   (deq_ready),
      .deq_bits_o    (deq_bits),
      .count_o       (count),
      .ram_wr_addr_o (wr_addr),
      .ram_wr_data_o (wr_data),
      .ram_wr_csb_o  (wr_csb),
      .ram_wr_web_o  (wr_web),
      .ram_rd_addr_o (rd_addr),
      .ram_rd_csb_o  (rd_csb),
      .ram_rd_oeb_o  (rd_oeb),
      .ram_rd_data_i (rd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural macro: synchronous write, registered read
   logic [63:0] mem [32];
   always @(posedge clk) begin
      if (!wr_csb && !wr_web) mem[wr_addr] <= wr_data;
      if (!rd_csb) rd_data <= mem[rd_addr];
   end

   int          total = 0;
   int          bad   = 0;
   logic [63:0] sb [$];
   int          cnt_m = 0;
   int          n_enq = 0;
   int          n_deq = 0;
   int          wr_wraps = 0;
   int          rd_wraps = 0;
   int          prev_wa = 0;
   int          prev_ra = 0;
   logic        s_enq_f, s_deq_f, s_deq_valid, s_enq_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample one cycle at the falling edge, update scoreboard, advance past the rising edge
   task automatic tick();
      logic [63:0] exp_w;
      @(negedge clk);
      s_enq_f     = enq_valid & enq_ready;
      s_deq_f     = deq_valid & deq_ready;
      s_deq_valid = deq_valid;
      s_enq_ready = enq_ready;
      chk("count", 64'(count), 64'(cnt_m));
      chk("web_eq_csb", 64'(wr_web), 64'(wr_csb));
      chk("oeb", 64'(rd_oeb), 64'd0);
      chk("no_collision", 64'(!wr_csb && !rd_csb && (wr_addr == rd_addr)), 64'd0);
      if (s_enq_f) begin
         sb.push_back(enq_bits);
         cnt_m++;
         n_enq++;
      end
      if (s_deq_f) begin
         exp_w = (sb.size() > 0) ? sb.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
         chk("deq_bits", deq_bits, exp_w);
         cnt_m--;
         n_deq++;
      end
      if (!wr_csb) begin
         if (wr_addr == 5'd0 && prev_wa == 24) wr_wraps++;
         prev_wa = int'(wr_addr);
      end
      if (!rd_csb) begin
         if (rd_addr == 5'd0 && prev_ra == 24) rd_wraps++;
         prev_ra = int'(rd_addr);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      for (int i = 0; i < 80 && sb.size() > 0; i++) tick();
      chk(tag, 64'(sb.size()), 64'd0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, accepted0, last_fire, first_low, bubbles, e0, d0, v;
      rst = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("rst_enq_ready", 64'(enq_ready), 64'd1);
      chk("rst_deq_valid", 64'(deq_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_wr_csb", 64'(wr_csb), 64'd1);
      chk("rst_wr_web", 64'(wr_web), 64'd1);
      chk("rst_rd_csb", 64'(rd_csb), 64'd1);
      chk("rst_rd_oeb", 64'(rd_oeb), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_rd_addr", 64'(rd_addr), 64'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      chk("rst_deq_bits", deq_bits, 64'd0);
      @(posedge clk); #1;

      // Single-word latency
      deq_ready = 1'b1; enq_valid = 1'b1; enq_bits = 64'h0123_4567_89AB_CDEF;
      tick();
      enq_valid = 1'b0; enq_bits = '0;
      lat = -1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (s_deq_valid && lat < 0) lat = c;
      end
      chk("latency", 64'(lat), 64'(LAT));
      chk("latency_sb_empty", 64'(sb.size()), 64'd0);
      chk("latency_count", 64'(count), 64'd0);

      // Fill to capacity with the consumer stalled
      deq_ready = 1'b0; enq_valid = 1'b1; enq_bits = 64'd0;
      accepted0 = n_enq; last_fire = -1; first_low = -1; v = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (s_enq_f) begin
            last_fire = c;
            v++;
            enq_bits = 64'(v);
         end
         if (!s_enq_ready && first_low < 0) first_low = c;
      end
      chk("fill_accepted", 64'(n_enq - accepted0), 64'd27);
      chk("fill_ready_drop_cycle", 64'(first_low), 64'(last_fire + 1));
      chk("fill_enq_ready", 64'(enq_ready), 64'd0);
      chk("fill_count", 64'(count), 64'd27);
      drain("fill_drain_empty");
      chk("drain_enq_ready", 64'(enq_ready), 64'd1);
      chk("drain_deq_valid", 64'(deq_valid), 64'd0);

      // Back-to-back streaming
      e0 = n_enq; d0 = n_deq; bubbles = 0; wr_wraps = 0; rd_wraps = 0; v = 1000;
      enq_valid = 1'b1; deq_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         enq_bits = 64'(v);
         tick();
         if (s_enq_f) v++;
         if (c >= LAT && !s_deq_f) bubbles++;
      end
      chk("stream_enq_count", 64'(n_enq - e0), 64'd100);
      chk("stream_deq_count", 64'(n_deq - d0), 64'(100 - LAT));
      chk("stream_bubbles", 64'(bubbles), 64'd0);
`ifndef FIFO_BYPASS_EN
      chk("stream_wr_wraps_ge3", 64'(wr_wraps >= 3), 64'd1);
      chk("stream_rd_wraps_ge3", 64'(rd_wraps >= 3), 64'd1);
`endif
      drain("stream_drain_empty");

      // Random traffic
      for (int c = 0; c < 2000; c++) begin
         enq_valid = 1'($urandom_range(0, 1));
         deq_ready = 1'($urandom_range(0, 1));
         enq_bits  = {$urandom, $urandom};
         tick();
      end
      drain("random_drain_empty");

      // Reset while a read is in flight
      deq_ready = 1'b0; enq_valid = 1'b1; e0 = n_enq;
      for (int c = 0; c < 40 && (n_enq - e0) < 10; c++) begin
         enq_bits = 64'h100 + 64'(n_enq - e0);
         tick();
      end
      enq_valid = 1'b0;
      repeat (4) tick();
      deq_ready = 1'b1;
      tick();
      deq_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_deq_valid", 64'(deq_valid), 64'd0);
      chk("midrst_enq_ready", 64'(enq_ready), 64'd1);
      sb.delete();
      cnt_m = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      d0 = n_deq;
      enq_valid = 1'b1; deq_ready = 1'b1; enq_bits = 64'hA5;
      tick();
      enq_valid = 1'b0;
      drain("midrst_drain_empty");
      chk("midrst_deq_count", 64'(n_deq - d0), 64'd1);
      chk("midrst_final_count", 64'(count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
